// File: rtl/scope_frontend_req_capture_pkg.sv
// Shared types for the frontend-request trace capture stage.
// Optional feature macro: SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN adds a
// per-entry inter-capture cycle delta.
package scope_frontend_capture_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StPost,
      StDone
   } cap_state_e;

   localparam int unsigned TS_W       = 16;
   localparam int unsigned ENTRY_PC_W = 32;

   // Canonical entry layout at the default PC width.
`ifdef SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN
   typedef struct packed {
      logic [TS_W-1:0]       delta;
      logic [ENTRY_PC_W-1:0] pc;
   } entry_t;
`else
   typedef struct packed {
      logic [ENTRY_PC_W-1:0] pc;
   } entry_t;
`endif

endpackage

// File: rtl/scope_frontend_req_capture_if.sv
// Probe request and readout handshake bundle for the capture stage.
// Optional feature macro: SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN adds rd_delta.
interface scope_frontend_req_capture_if #(
   parameter int unsigned PC_WIDTH = 32
);
   import scope_frontend_capture_pkg::*;

   logic                req_valid;
   logic [PC_WIDTH-1:0] req_pc;
   logic                rd_valid;
   logic                rd_ready;
   logic [PC_WIDTH-1:0] rd_pc;
`ifdef SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN
   logic [TS_W-1:0]     rd_delta;

   modport master (output req_valid, req_pc, rd_ready, input rd_valid, rd_pc, rd_delta);
   modport slave  (input req_valid, req_pc, rd_ready, output rd_valid, rd_pc, rd_delta);
`else
   modport master (output req_valid, req_pc, rd_ready, input rd_valid, rd_pc);
   modport slave  (input req_valid, req_pc, rd_ready, output rd_valid, rd_pc);
`endif

endinterface

// File: rtl/scope_frontend_req_capture_ram.sv
// History storage: flop array, one write port, one asynchronous read port, no reset.
module scope_capture_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port; contents intentionally left unreset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/scope_frontend_req_capture.sv
// Frontend-request trace capture: circular PC history, trigger + post-count
// freeze, oldest-first drain over a valid/ready port.
// Optional feature macro: SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN.
module scope_frontend_req_capture
   import scope_frontend_capture_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned PC_WIDTH = 32,
   localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset,
   scope_frontend_req_capture_if.slave bus,
   input  logic                        arm,
   input  logic                        trigger,
   input  logic [PTR_W-1:0]            post_count,
   output logic                        busy,
   output logic                        wrapped,
   output logic [PTR_W:0]              fill
);

`ifdef SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN
   localparam int unsigned ENT_W = PC_WIDTH + TS_W;
`else
   localparam int unsigned ENT_W = PC_WIDTH;
`endif
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   cap_state_e       state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   fill_q, fill_d;
   logic             wrapped_q, wrapped_d;
   logic [PTR_W-1:0] remaining_q, remaining_d;
   logic             cap, rd_valid;
   logic [ENT_W-1:0] wr_data, rd_data;

`ifdef SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN
   logic [TS_W-1:0] delta_q, delta_d, delta_cap;

   // Saturating cycle count including the current cycle.
   assign delta_cap = (delta_q == '1) ? delta_q : delta_q + TS_W'(1);
   assign wr_data   = {delta_cap, bus.req_pc};

   // Delta counter restarts on arm and on every capture.
   always_comb begin
      delta_d = delta_cap;
      if (arm || cap) begin
         delta_d = '0;
      end
   end

   // Delta counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         delta_q <= '0;
      end else begin
         delta_q <= delta_d;
      end
   end

   assign bus.rd_delta = rd_valid ? rd_data[PC_WIDTH +: TS_W] : '0;
`else
   assign wr_data = bus.req_pc;
`endif

   assign rd_valid   = (state_q == StDone) && (fill_q != '0);
   assign bus.rd_valid = rd_valid;
   assign bus.rd_pc  = rd_valid ? rd_data[PC_WIDTH-1:0] : '0;
   assign busy       = (state_q == StArmed) || (state_q == StPost);
   assign wrapped    = wrapped_q;
   assign fill       = fill_q;

   // Next-state logic: arm overrides everything, then capture and readout.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      wrapped_d   = wrapped_q;
      remaining_d = remaining_q;
      cap         = 1'b0;
      if (arm) begin
         state_d     = StArmed;
         wr_ptr_d    = '0;
         fill_d      = '0;
         wrapped_d   = 1'b0;
         remaining_d = '0;
      end else begin
         cap = ((state_q == StArmed) || (state_q == StPost)) && bus.req_valid;
         if (cap) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (fill_q == FULL) begin
               wrapped_d = 1'b1;
            end else begin
               fill_d = fill_q + (PTR_W+1)'(1);
            end
         end
         unique case (state_q)
            StIdle: begin
            end
            StArmed: begin
               if (trigger) begin
                  if (post_count == '0) begin
                     state_d  = StDone;
                     rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
                  end else begin
                     state_d     = StPost;
                     remaining_d = post_count;
                  end
               end
            end
            StPost: begin
               if (cap) begin
                  if (remaining_q == PTR_W'(1)) begin
                     state_d  = StDone;
                     rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
                  end
                  remaining_d = remaining_q - PTR_W'(1);
               end
            end
            StDone: begin
               if (fill_q == '0) begin
                  state_d = StIdle;
               end else if (bus.rd_ready) begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                  fill_d   = fill_q - (PTR_W+1)'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         wrapped_q   <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         wrapped_q   <= wrapped_d;
         remaining_q <= remaining_d;
      end
   end

   scope_capture_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_ram (
      .clock   (clock),
      .wr_en   (cap),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_scope_frontend_req_capture.sv
// Scoreboard bench for scope_frontend_req_capture (default DEPTH=16).
// Timestamp scenario runs when SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN is defined.
module tb_scope_frontend_req_capture;
   import scope_frontend_capture_pkg::*;

   localparam int unsigned DEPTH    = 16;
   localparam int unsigned PC_WIDTH = 32;
   localparam int unsigned PTR_W    = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             arm = 1'b0;
   logic             trigger = 1'b0;
   logic [PTR_W-1:0] post_count = '0;
   logic             busy, wrapped;
   logic [PTR_W:0]   fill;

   scope_frontend_req_capture_if #(.PC_WIDTH(PC_WIDTH)) bus ();

   scope_frontend_req_capture #(
      .DEPTH    (DEPTH),
      .PC_WIDTH (PC_WIDTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .arm        (arm),
      .trigger    (trigger),
      .post_count (post_count),
      .busy       (busy),
      .wrapped    (wrapped),
      .fill       (fill)
   );

   always #5 clock = ~clock;

   // Reference model: history queue, frozen readout queue, mode flags.
   logic [31:0] hist_pc[$];
   int          hist_dt[$];
   logic [31:0] exp_pc[$];
   int          exp_dt[$];
   int          m_state;   // 0 not capturing, 1 armed, 2 post-trigger
   int          m_rem;
   bit          m_wrapped;
   bit          m_readout;
   longint      cyc;
   longint      last_evt;
   int          checks;
   int          errors;
   bit          mon_en;
   bit          prev_stall;
   logic [31:0] prev_pc;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic freeze();
      exp_pc    = hist_pc;
      exp_dt    = hist_dt;
      m_readout = 1'b1;
      m_state   = 0;
   endtask

   // Applies the rules for one clock edge given that edge's inputs.
   task automatic model_edge(input bit r, input bit a, input bit t, input bit rv,
                             input logic [31:0] pc, input int pcnt);
      bit captured;
      longint d;
      captured = 1'b0;
      if (r) begin
         hist_pc.delete(); hist_dt.delete(); exp_pc.delete(); exp_dt.delete();
         m_state = 0; m_wrapped = 1'b0; m_readout = 1'b0; m_rem = 0;
         return;
      end
      if (a) begin
         hist_pc.delete(); hist_dt.delete(); exp_pc.delete(); exp_dt.delete();
         m_state = 1; m_wrapped = 1'b0; m_readout = 1'b0; last_evt = cyc;
         return;
      end
      if (m_state != 0 && rv) begin
         d = cyc - last_evt;
         last_evt = cyc;
         if (hist_pc.size() == DEPTH) begin
            void'(hist_pc.pop_front());
            void'(hist_dt.pop_front());
            m_wrapped = 1'b1;
         end
         hist_pc.push_back(pc);
         hist_dt.push_back((d > 65535) ? 65535 : int'(d));
         captured = 1'b1;
      end
      if (m_state == 1 && t) begin
         if (pcnt == 0) freeze();
         else begin
            m_state = 2;
            m_rem   = pcnt;
         end
      end else if (m_state == 2 && captured) begin
         m_rem--;
         if (m_rem == 0) freeze();
      end
   endtask

   task automatic step(input bit r, input bit a, input bit t, input bit rv,
                       input logic [31:0] pc, input int pcnt, input bit rdy);
      reset         = r;
      arm           = a;
      trigger       = t;
      bus.req_valid = rv;
      bus.req_pc    = pc;
      post_count    = PTR_W'(pcnt);
      bus.rd_ready  = rdy;
      @(posedge clock);
      cyc++;
      model_edge(r, a, t, rv, pc, pcnt);
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0, rdy);
   endtask

   task automatic drain(input bit random_ready);
      int budget;
      budget = 0;
      while (exp_pc.size() != 0 && budget < 400) begin
         step(0, 0, 0, 0, 32'h0, 0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         budget++;
      end
      if (exp_pc.size() != 0) check("drain_timeout", exp_pc.size(), 0);
      idle(2, 1'b1);
   endtask

   // Monitor: compares DUT outputs to the model and retires accepted entries.
   always @(negedge clock) begin
      bit          ev;
      logic [31:0] epc;
      if (mon_en) begin
         ev  = m_readout && (exp_pc.size() != 0);
         epc = ev ? exp_pc[0] : 32'h0;
         check("busy", busy, (m_state != 0));
         check("wrapped", wrapped, m_wrapped);
         check("fill", fill, m_readout ? exp_pc.size() : hist_pc.size());
         check("rd_valid", bus.rd_valid, ev);
         check("rd_pc", bus.rd_pc, epc);
`ifdef SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN
         check("rd_delta", bus.rd_delta, ev ? exp_dt[0] : 0);
`endif
         if (prev_stall && bus.rd_valid) check("rd_pc_stable", bus.rd_pc, prev_pc);
         prev_stall = bus.rd_valid && !bus.rd_ready && !arm && !reset;
         prev_pc    = bus.rd_pc;
         if (ev && bus.rd_ready && !arm && !reset) begin
            void'(exp_pc.pop_front());
            void'(exp_dt.pop_front());
         end
      end
   end

   initial begin
      checks = 0; errors = 0; cyc = 0; last_evt = 0;
      m_state = 0; m_rem = 0; m_wrapped = 0; m_readout = 0;
      mon_en = 0; prev_stall = 0; prev_pc = 0;
      bus.req_valid = 1'b0; bus.req_pc = '0; bus.rd_ready = 1'b0;

      step(1, 0, 0, 0, 32'h0, 0, 0);
      step(1, 0, 0, 0, 32'h0, 0, 0);
      mon_en = 1'b1;
      step(0, 0, 0, 0, 32'h0, 0, 1);

      // Reset in the middle of the post-trigger window.
      step(0, 1, 0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h500 + 32'(4 * i), 0, 0);
      step(0, 0, 1, 1, 32'h50C, 5, 0);
      step(0, 0, 0, 1, 32'h510, 0, 0);
      check("pre_reset_fill", fill, 5);
      step(1, 0, 0, 0, 32'h0, 0, 0);
      check("reset_fill", fill, 0);
      check("reset_busy", busy, 0);
      step(0, 0, 1, 0, 32'h0, 0, 1);
      check("trig_idle_busy", busy, 0);

      // Wrap: 20 captures into 16 entries, trigger on the last one.
      step(0, 1, 0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 20; i++)
         step(0, 0, (i == 19), 1, 32'h1000 + 32'(4 * i), 0, 0);
      check("wrap_wrapped", wrapped, 1);
      check("wrap_fill", fill, 16);
      check("wrap_oldest", bus.rd_pc, 32'h1010);
      drain(1'b0);

      // Post-trigger count ignores idle cycles and stops after two samples.
      step(0, 1, 0, 0, 32'h0, 0, 0);
      step(0, 0, 0, 1, 32'h2000, 0, 0);
      step(0, 0, 0, 1, 32'h2004, 0, 0);
      step(0, 0, 1, 1, 32'h2008, 2, 0);
      idle(3, 1'b0);
      step(0, 0, 0, 1, 32'h200C, 0, 0);
      step(0, 0, 0, 1, 32'h2010, 0, 0);
      step(0, 0, 0, 1, 32'h2014, 0, 0);
      check("post_fill", fill, 5);
      check("post_wrapped", wrapped, 0);
      drain(1'b0);

      // Backpressure: stall four cycles, then random ready.
      step(0, 1, 0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, $urandom, 0, 0);
      step(0, 0, 1, 0, 32'h0, 0, 0);
      idle(4, 1'b0);
      drain(1'b1);

      // arm beats trigger; arm abandons a readout with 7 entries.
      step(0, 1, 1, 0, 32'h0, 0, 0);
      check("arm_trig_busy", busy, 1);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 32'h3000 + 32'(4 * i), 0, 0);
      step(0, 0, 1, 0, 32'h0, 0, 1);
      check("done7_fill", fill, 7);
      step(0, 1, 1, 1, 32'h3100, 0, 1);
      check("rearm_fill", fill, 0);
      check("rearm_busy", busy, 1);
      check("rearm_rd_valid", bus.rd_valid, 0);
      step(0, 0, 0, 1, 32'h3200, 0, 1);
      step(0, 0, 1, 1, 32'h3204, 0, 1);
      drain(1'b0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         step(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, DEPTH - 1)),
              1'($urandom_range(0, 1)));
      step(0, 0, 1, 0, 32'h0, 0, 1);
      drain(1'b1);

`ifdef SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN
      // Deltas: 3 cycles after arm, then a saturating gap.
      step(0, 1, 0, 0, 32'h0, 0, 0);
      idle(2, 1'b0);
      step(0, 0, 0, 1, 32'h4000, 0, 0);
      idle(69999, 1'b0);
      step(0, 0, 1, 1, 32'h4004, 0, 0);
      check("ts_first", bus.rd_delta, 3);
      step(0, 0, 0, 0, 32'h0, 0, 1);
      check("ts_sat", bus.rd_delta, 16'hFFFF);
      drain(1'b0);
`endif

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scope_frontend_req_capture.md
Name: scope_frontend_req_capture

Overview:
Trace-capture stage directly downstream of hart 0's frontend-request scope probe (valid + 32-bit fetch PC). Records fetch PCs into a circular history buffer while armed. Freezes the buffer after a trigger plus a programmable number of post-trigger samples. Drains the captured history oldest-first over a valid/ready read port to the debug/scope readout logic.

Parameters:
DEPTH, 16, history entries; power of 2, ≥2
PC_WIDTH, 32, width of captured fetch PC
PTR_W, $clog2(DEPTH), derived pointer width (localparam, not overridable)

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  frontend request valid (fetch issued this cycle)
req_pc  input  PC_WIDTH  fetch address qualified by req_valid
arm  input  1  pulse: clear history, start capture
trigger  input  1  pulse: begin post-trigger countdown (honoured only while ARMED)
post_count  input  PTR_W  samples to capture after the trigger sample; sampled on the trigger cycle
busy  output  1  state is ARMED or POST
wrapped  output  1  sticky: history overwrote oldest entry since last arm
fill  output  PTR_W+1  number of valid entries, 0..DEPTH
rd_valid  output  1  readout entry available
rd_ready  input  1  consumer accepts rd_pc
rd_pc  output  PC_WIDTH  oldest unread PC; forced 0 when rd_valid=0

Behaviour:
- Reset: state IDLE; wr_ptr=0, rd_ptr=0, fill=0, wrapped=0, remaining=0; busy=0, rd_valid=0, rd_pc=0. Array contents are not reset. Reset mid-capture or mid-readout discards everything.
- States: IDLE, ARMED, POST, DONE.
- Capture write (ARMED or POST, req_valid=1): mem[wr_ptr]<=req_pc; wr_ptr+=1 mod DEPTH; fill saturates at DEPTH. A write when fill==DEPTH sets wrapped.
- IDLE: no capture. arm → ARMED; clears wr_ptr, fill, wrapped.
- ARMED: capture each req_valid. trigger → POST with remaining=post_count. A req_valid on the trigger cycle is captured and is the trigger sample, not counted in post_count. If post_count==0 → DONE directly.
- POST: capture each req_valid. Cycles without req_valid do not count. On a capture with remaining==1 → DONE; otherwise remaining-=1. Further trigger pulses are ignored.
- DONE entry: rd_ptr<=(wrapped or final write wrapped) ? wr_ptr : 0, i.e. the oldest entry.
- DONE: rd_valid = (fill!=0); rd_pc = mem[rd_ptr], combinational from array with 0 read latency. On rd_valid&&rd_ready: rd_ptr+=1 mod DEPTH, fill-=1. When fill reaches 0 (including entering DONE with fill==0) → IDLE on the next cycle. req_valid is ignored.
- arm has priority in every state, including over trigger in the same cycle: → ARMED with history cleared. In DONE this abandons the readout. Any write/pop in that cycle is dropped.
- trigger in IDLE or DONE: ignored.
- rd_pc stable while rd_valid&&!rd_ready.

Optional Feature:
SIFIVE_SCOPE_FRONTEND_CAPTURE_TIMESTAMP_EN
- Defined: each entry also stores a 16-bit delta, the cycles since the previous capture (first entry after arm: cycles since arm). Delta saturates at 16'hFFFF. Extra output rd_delta [15:0], valid with rd_valid and forced 0 otherwise. The delta counter clears on arm and on each capture.
- Undefined: no counter, no delta storage, no rd_delta port.

Decomposition:
- Package scope_frontend_capture_pkg: state enum (IDLE/ARMED/POST/DONE), TS_W=16 constant, entry struct typedef (pc, plus delta when the macro is defined).
- Sub-module scope_capture_ram: DEPTH-entry flop array with 1 write port and 1 asynchronous read port, no reset. Control FSM and pointers live in the top.

Test Plan:
- Reset mid-POST with 5 entries captured → next cycle busy=0, fill=0, rd_valid=0, rd_pc=0; trigger alone then has no effect.
- DEPTH=16; arm; 20 PCs 0x1000+4i; trigger on i=19, post_count=0 → DONE, wrapped=1, fill=16; readout yields 0x1010..0x104C in order, then IDLE.
- arm; PCs 0x2000, 0x2004, 0x2008; trigger with req_valid on 0x2008, post_count=2; 3 idle cycles; PCs 0x200C, 0x2010, 0x2014 → captured 0x2000..0x2010 (fill=5), 0x2014 not captured, wrapped=0.
- Readout backpressure: rd_ready low 4 cycles then toggling → rd_pc held stable while stalled; each entry delivered exactly once.
- arm asserted with trigger, and arm during DONE with fill=7 → state ARMED, fill=0, rd_valid=0; trigger ignored that cycle.
- Timestamp build: arm, capture after 3 cycles, then after 70000 cycles → rd_delta reads 3 then 16'hFFFF.
